// File: rtl/velocity_cell_reader_if.sv
// rtl/velocity_cell_reader_if.sv - RAM read port and record stream bundle for the velocity cell reader
interface velocity_cell_reader_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);
  // Cell velocity RAM port
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_rden;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] mem_q;

  // Record stream towards the motion-update unit
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_index;
  logic                  out_last;

  // Reader side: drives the RAM port and produces records
  modport master (
    output mem_address, mem_rden, mem_wren, mem_data,
    input  mem_q,
    output out_valid, out_data, out_index, out_last,
    input  out_ready
  );

  // Environment side: the RAM and the record consumer
  modport slave (
    input  mem_address, mem_rden, mem_wren, mem_data,
    output mem_q,
    input  out_valid, out_data, out_index, out_last,
    output out_ready
  );
endinterface

// File: rtl/velocity_cell_reader.sv
// rtl/velocity_cell_reader.sv - fetches a cell's particle count and streams its velocity records
module velocity_cell_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_num,
  velocity_cell_reader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_CNT,
    S_WAIT_CNT,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;     // last address presented to the RAM
  logic                  rd_pend;    // record read issued last cycle; its data is on mem_q now

  // Two-entry output buffer absorbing the RAM read latency
  logic [DATA_WIDTH-1:0] buf_data  [2];
  logic [ADDR_WIDTH-1:0] buf_index [2];
  logic                  head;
  logic                  tail;
  logic [1:0]            occ;

  logic                  push;
  logic                  pop;
  logic                  issue;
  logic [2:0]            fill_level;
  logic [1:0]            occ_next;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] cnt_raw;
  logic [ADDR_WIDTH-1:0] cnt_clamped;

  assign cnt_raw     = bus.mem_q[ADDR_WIDTH-1:0];
  assign cnt_clamped = (cnt_raw > MAX_CNT) ? MAX_CNT : cnt_raw;

  assign push       = rd_pend;
  assign pop        = bus.out_valid & bus.out_ready;
  assign fill_level = {1'b0, occ} + {2'b00, rd_pend};
  assign occ_next   = occ + {1'b0, push} - {1'b0, pop};
  assign next_addr  = addr_q + ONE;

  // A read is only launched when its data is guaranteed a free slot on return,
  // crediting the entry leaving the buffer this cycle so a ready consumer gets
  // one record per cycle.
  assign issue = (state == S_STREAM) && (addr_q != particle_num) &&
                 (fill_level < (3'd2 + {2'b00, pop}));

  assign bus.mem_rden    = (state == S_RD_CNT) | issue;
  assign bus.mem_address = issue ? next_addr : addr_q;
  assign bus.mem_wren    = 1'b0;
  assign bus.mem_data    = '0;

  assign bus.out_valid = (occ != 2'd0);
  assign bus.out_data  = bus.out_valid ? buf_data[head]  : '0;
  assign bus.out_index = bus.out_valid ? buf_index[head] : '0;
  assign bus.out_last  = bus.out_valid && (buf_index[head] == particle_num);

  // Control sequencing: count fetch, record streaming, drain and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      particle_num <= '0;
      addr_q       <= '0;
      rd_pend      <= 1'b0;
    end else begin
      done    <= 1'b0;
      rd_pend <= issue;
      if (issue) begin
        addr_q <= next_addr;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_RD_CNT;
            busy   <= 1'b1;
            addr_q <= '0;
          end
        end
        S_RD_CNT: begin
          state <= S_WAIT_CNT;
        end
        S_WAIT_CNT: begin
          particle_num <= cnt_clamped;
          if (cnt_clamped != '0) begin
            state <= S_STREAM;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_STREAM: begin
          if (issue && (next_addr == particle_num)) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Finish as soon as the final record leaves, so done follows it directly
          if (occ_next == 2'd0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output buffer: returning RAM data enters at the tail tagged with its address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= 1'b0;
      tail <= 1'b0;
      occ  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i]  <= '0;
        buf_index[i] <= '0;
      end
    end else begin
      assert (!(push && !pop && (occ == 2'd2)));
      if (push) begin
        buf_data[tail]  <= bus.mem_q;
        buf_index[tail] <= addr_q;
        tail            <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      occ <= occ_next;
    end
  end

endmodule
